// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Bus-side initiator for a word-addressed 32-bit memory with active-low read
// and write strobes. Accepts RV32I load/store requests, extracts and extends
// sub-word load data, and performs read-modify-write for SB/SH because the
// memory has no byte enables.
//
// Parameters
//   WORDS       log2 of memory depth in 32-bit words (word address width)
//   DATA_WIDTH  data width, only 32 is supported
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   reset_i      synchronous active-high reset
//   req_i        request strobe, sampled only while busy_o=0
//   we_i         1 = store, 0 = load
//   funct3_i     RV32I width code
//   addr_i       byte address
//   wdata_i      right-aligned store data
//   rdata_o      extended load result, holds until the next load completes
//   done_o       one-cycle completion pulse
//   fault_o      valid with done_o: request rejected, no memory access
//   busy_o       high whenever a request is in flight
//   mem_addr_o   word address to memory
//   mem_data_o   write data to memory
//   mem_data_i   read data from memory
//   mem_wr_o     write strobe, active-low
//   mem_rd_o     read strobe, active-low
//
// Build option
//   MISALIGN_TRAP_EN  when defined, misaligned half/word accesses fault; when
//                     undefined, the low address bits are forced to alignment.
//
// State        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | waiting for req_i; request fields latched on acceptance
// S_READ       | mem_rd_o low; load lane extracted or store word merged
// S_WRITE      | mem_wr_o low; full word written
// S_DONE       | done_o pulse (with fault_o if rejected), then back to idle
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int WORDS      = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  done_o,
    output logic                  fault_o,
    output logic                  busy_o,
    output logic [WORDS-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  mem_wr_o,
    output logic                  mem_rd_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_WRITE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            lane_q, lane_d;
    logic [15:0]           wdata_lo_q, wdata_lo_d;
    logic                  fault_q, fault_d;
    logic [WORDS-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  rd_n_q, rd_n_d;
    logic                  wr_n_q, wr_n_d;

    logic                  illegal;
    logic                  reject;
    logic [1:0]            lane_in;
    logic                  unused_addr_hi;

    // Bits above the word address are intentionally ignored (address wrap).
    assign unused_addr_hi = ^addr_i[31:WORDS+2];

    // -------------------------------------------------------------------------
    // Lane extraction for loads: byte lane = addr[1:0], half lane = addr[1].
    // -------------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] extract_lane(
        input logic [DATA_WIDTH-1:0] word,
        input logic [2:0]            f3,
        input logic [1:0]            lane
    );
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b001:  r = {{(DATA_WIDTH-16){h[15]}}, h};
            3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, b};
            3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Store merge: replace the addressed byte/half, keep everything else.
    // -------------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] word,
        input logic [2:0]            f3,
        input logic [1:0]            lane,
        input logic [15:0]           d
    );
        logic [DATA_WIDTH-1:0] r;
        r = word;
        case (f3[1:0])
            2'b00: begin
                case (lane)
                    2'd0:    r[7:0]   = d[7:0];
                    2'd1:    r[15:8]  = d[7:0];
                    2'd2:    r[23:16] = d[7:0];
                    default: r[31:24] = d[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    r[31:16] = d;
                end else begin
                    r[15:0] = d;
                end
            end
            default: r = word;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Request legality, evaluated on the incoming fields in the acceptance
    // cycle (identical to checking the latched copy one cycle later).
    // -------------------------------------------------------------------------
`ifdef MISALIGN_TRAP_EN
    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (funct3_i[1:0])
            2'b01:   misaligned = addr_i[0];
            2'b10:   misaligned = |addr_i[1:0];
            default: misaligned = 1'b0;
        endcase
    end
`endif

    always_comb begin
        illegal = 1'b0;
        reject  = 1'b0;
        lane_in = addr_i[1:0];
        if (we_i) begin
            illegal = funct3_i[2] || (funct3_i[1:0] == 2'b11);
        end else begin
            illegal = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
        end
`ifdef MISALIGN_TRAP_EN
        reject  = illegal || misaligned;
        lane_in = addr_i[1:0];
`else
        // Misalignment is silently absorbed by forcing the low bits.
        reject = illegal;
        case (funct3_i[1:0])
            2'b01:   lane_in = {addr_i[1], 1'b0};
            2'b10:   lane_in = 2'b00;
            default: lane_in = addr_i[1:0];
        endcase
`endif
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        lane_d     = lane_q;
        wdata_lo_d = wdata_lo_q;
        fault_d    = fault_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        rdata_d    = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d       = we_i;
                    funct3_d   = funct3_i;
                    lane_d     = lane_in;
                    wdata_lo_d = wdata_i[15:0];
                    mem_addr_d = addr_i[WORDS+1:2];
                    fault_d    = reject;
                    if (reject) begin
                        state_d = S_DONE;
                    end else if (we_i && (funct3_i[1:0] == 2'b10)) begin
                        // Full-word store skips the read.
                        mem_data_d = wdata_i;
                        state_d    = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (we_q) begin
                    mem_data_d = merge_word(mem_data_i, funct3_q, lane_q, wdata_lo_q);
                    state_d    = S_WRITE;
                end else begin
                    rdata_d = extract_lane(mem_data_i, funct3_q, lane_q);
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes and done are registered from the next state so they are
        // glitch-free and stable for the whole cycle they belong to.
        rd_n_d = (state_d != S_READ);
        wr_n_d = (state_d != S_WRITE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            lane_q     <= 2'b00;
            wdata_lo_q <= 16'h0000;
            fault_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            lane_q     <= lane_d;
            wdata_lo_q <= wdata_lo_d;
            fault_q    <= fault_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
        end
    end

    assign rdata_o    = rdata_q;
    assign done_o     = done_q;
    assign fault_o    = done_q & fault_q;
    assign busy_o     = (state_q != S_IDLE);
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign mem_rd_o   = rd_n_q;
    assign mem_wr_o   = wr_n_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Bus-side initiator for the 1K×32 BRAM word memory: accepts RV32I load/store requests (byte address, funct3, store data) from the multicycle control path and drives the memory's word-addressed, active-low read/write strobes. Sub-word loads are extracted and sign/zero-extended. Sub-word stores use a read-modify-write sequence because the memory has no byte enables. Sits between the datapath/control FSM and the Memory block.

## Interface
- WORDS, 10, log2 of memory depth in 32-bit words
- DATA_WIDTH, 32, data width; only 32 is supported
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- req_i  in  1  request strobe; sampled only while busy_o=0
- we_i  in  1  1 = store, 0 = load
- funct3_i  in  3  RV32I width code: loads LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SB 000, SH 001, SW 010
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-aligned
- rdata_o  out  32  load result, extended; holds until next load completes
- done_o  out  1  one-cycle completion pulse
- fault_o  out  1  valid with done_o: request rejected, no memory access
- busy_o  out  1  high in every non-IDLE state
- mem_addr_o  out  WORDS  word address = captured addr[WORDS+1:2]
- mem_data_o  out  32  write data to memory
- mem_data_i  in  32  read data from memory
- mem_wr_o  out  1  write strobe, active-low
- mem_rd_o  out  1  read strobe, active-low

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE + req_i=1: latch we_i, funct3_i, addr_i, wdata_i. Later input changes are ignored until return to IDLE.
- Legality check on latched values:
  - illegal funct3 (load 011/110/111, store with bit2=1) → DONE with fault_o=1
  - misaligned access → DONE with fault_o=1 (see Configuration)
- Legal paths:
  - SW → WRITE
  - load, SB, SH → READ
- READ: mem_rd_o=0.
  - Load: at end of cycle, extract lane from mem_data_i into rdata_o → DONE.
  - SB/SH: at end of cycle, register merged word into mem_data_o → WRITE.
- WRITE: mem_wr_o=0 → DONE. SW drives wdata_i unchanged.
- DONE: done_o=1, fault_o as decided → IDLE. No new request is accepted in DONE.
- Lane selection:
  - byte lane = addr[1:0], bits [8·lane+7 : 8·lane]
  - half lane = addr[1], bits [16·h+15 : 16·h]
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through
- Merge: SB replaces the addressed byte with wdata_i[7:0]; SH replaces the addressed half with wdata_i[15:0]; all other bits come from mem_data_i.
- Address bits above WORDS+1 are ignored, so addresses wrap modulo 2^WORDS words.

## Timing
- Memory samples strobes on its falling edge. Strobes and address are driven from rising-edge registers and are stable for the whole cycle. Read data is valid before the next rising edge.
- Cycle 0 is the cycle in which req_i is sampled high.
- Latency:
  - load: READ in cycle 1, done_o in cycle 2
  - SW: WRITE in cycle 1, done_o in cycle 2
  - SB/SH: READ in cycle 1, WRITE in cycle 2, done_o in cycle 3
  - fault: done_o + fault_o in cycle 1
- Minimum request spacing: next request is accepted in the cycle after done_o.
- At most one strobe is low in any cycle; both are never low together.
- Reset values:
  - state IDLE
  - rdata_o, mem_addr_o, mem_data_o = 0
  - done_o, fault_o, busy_o = 0
  - mem_wr_o, mem_rd_o = 1
- Reset mid-operation: a strobe already driven in the current cycle completes at that cycle's falling edge. From the reset edge on, both strobes are high, the transaction is dropped and no done_o is issued. reset_i outranks req_i.

## Configuration
- MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, produce a fault (done_o+fault_o in cycle 1, no strobes).
- Undefined: misalignment is never faulted. Half accesses force addr[0]=0; word accesses force addr[1:0]=0. fault_o then flags only illegal funct3.

## Test plan
- Reset held for 2 cycles with req_i=1 → all outputs at reset values, strobes high, busy_o=0.
- mem[5]=0x1111000B; LW addr 0x14 → mem_rd_o low in cycle 1 only, done_o in cycle 2, rdata_o=0x1111000B.
- mem[18]=0xD0B0A090; LB 0x4B → 0xFFFFFFD0; LBU 0x49 → 0x000000A0; LH 0x4A → 0xFFFFD0B0; LHU 0x48 → 0x0000A090.
- mem[2]=0x00000006; SB 0x0A with wdata 0x123456EE → READ then WRITE; mem[2]=0x00EE0006, done_o in cycle 3. Then SW 0x0C with wdata 0xCAFEBABE → mem[3]=0xCAFEBABE, done_o in cycle 2.
- With MISALIGN_TRAP_EN: LW 0x15 → fault_o=1 in cycle 1, no strobe. Without it: same request reads mem[5]. Load funct3 011 → fault in both builds.
- reset_i asserted during the READ cycle of an SH → mem_wr_o never goes low, no done_o, memory unchanged. A new LW is then accepted normally.
